pipelined_line_memory: RTL and testbench
========================================

Name: pipelined_line_memory

Overview:
- Behavioural main-memory model that serves cache refills and writebacks.
- Wide multi-word lines, per-word write mask, fixed pipelined latency, up to MAX_OUTSTANDING requests in flight.
- Valid/ready handshake on both request and response channels.
- Sits below the cache controller as the next-level memory, replacing the single-outstanding, no-backpressure model.

Parameters:
ADDRESS_WIDTH  32  byte-address width
WORD_WIDTH  32  bits per word (multiple of 8)
LINE_WORDS  4  words per line (power of 2)
ENTRIES  1024  number of lines (power of 2)
DELAY  4  accept-to-respValid latency in cycles (>=1)
MAX_OUTSTANDING  4  max accepted-but-not-yet-returned requests (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
reqValid  in  1  request present
reqReady  out  1  model can accept request
reqAddress  in  ADDRESS_WIDTH  byte address
reqWen  in  1  1 = write, 0 = read
reqDataIn  in  LINE_WORDS*WORD_WIDTH  write line, word 0 in LSBs
reqWordMask  in  LINE_WORDS  per-word write enable (writes only)
respValid  out  1  response present
respReady  in  1  consumer takes response
respDataOut  out  LINE_WORDS*WORD_WIDTH  line contents
respWrite  out  1  response is a write acknowledge
inflight  out  clog2(MAX_OUTSTANDING+1)  accepted, not yet returned

Behaviour:
- Line index = reqAddress[OFF +: clog2(ENTRIES)], where OFF = clog2(LINE_WORDS*WORD_WIDTH/8).
- Bits below OFF are ignored. Bits above the index are ignored (aliasing).
- Array is zero-initialised at time 0. It is NOT cleared by reset.
- Accept occurs at a rising edge with reqValid & reqReady.
- reqReady = rst_n & (inflight < MAX_OUTSTANDING).
  - Computed from registered count only; no combinational path from respReady.
  - At full, a same-cycle response pop does not raise reqReady until the next cycle.
- Write accept:
  - Words with reqWordMask[i]=1 are updated at the accept edge; others are unchanged.
  - A mask of all zero writes nothing but still returns an acknowledge.
- Read accept: line is snapshotted at the accept edge. Later writes do not alter that response.
- Read after write to the same line, accepted on the next edge: read returns the new data.
- Response payload:
  - Write: respWrite=1; respDataOut = post-write line contents.
  - Read: respWrite=0; respDataOut = snapshot.
- Latency:
  - Accept at edge E: the entry enters a DELAY-stage valid/data shift pipeline.
  - It is visible at the pipeline tail after edge E+DELAY.
  - The tail pushes into an output FIFO of depth MAX_OUTSTANDING; the FIFO head drives respValid and respDataOut.
  - With an empty FIFO and respReady=1, respValid rises exactly DELAY cycles after accept.
- Ordering: strictly in acceptance order.
- Throughput: one accept and one return per cycle when unstalled.
- Stall: respValid=1 with respReady=0 holds respDataOut and respWrite stable. The pipeline keeps advancing into the FIFO.
  - The FIFO cannot overflow because inflight <= MAX_OUTSTANDING bounds all stored entries.
  - Overflow is an assertion failure.
- inflight: +1 on accept, -1 on response handshake (respValid & respReady). Simultaneous accept and pop leaves it unchanged.
- FIFO pointers wrap modulo depth. Empty/full are distinguished by the count.
- Reset, asserted asynchronously at any time:
  - Clears pipeline valids, FIFO pointers/count, inflight, respValid, respWrite and respDataOut (all 0).
  - reqReady = 0 while rst_n = 0.
  - In-flight requests are discarded. Writes already applied stay in the array.
  - First accept is possible on the first rising edge after rst_n deasserts.

Test Plan:
- Single read, DELAY=4, line 5 preloaded with {0x33,0x22,0x11,0x00} -> respValid high exactly 4 cycles after accept; data 0x00000033_00000022_00000011_00000000; respWrite=0; inflight returns to 0.
- Masked write to 0x40 (line 4), data {D,C,B,A}, mask 0101, then read 0x40 -> write ack carries {0,C,0,A}; read returns {0,C,0,A}; addresses 0x44..0x4C alias to the same line.
- Back-to-back 6 reads with respReady=0, MAX_OUTSTANDING=4 -> reqReady drops after 4th accept; 5th not accepted; inflight=4; then respReady=1 -> 4 in-order responses; reqReady reasserts the cycle after the first pop; remaining reads complete.
- Full pipe with same-cycle accept and pop at inflight=3 -> inflight stays 3; at inflight=4, a pop leaves reqReady=0 that cycle and sets it to 1 the next.
- Read line 7 (old 0x1), then next cycle write line 7 = 0x9 -> read response 0x1, write ack 0x9, in that order.
- rst_n pulsed low asynchronously with 3 requests in flight (one a write) -> respValid/inflight immediately 0, reqReady 0 during reset; no stale responses after release; the write persists on later read.

Source files
------------

// File: rtl/pipelined_line_memory_if.sv
// Request/response bus between a cache controller (master) and the line memory (slave).
// Valid/ready handshake on both channels plus the outstanding-request count.
interface pipelined_line_memory_if #(
  parameter int unsigned ADDRESS_WIDTH   = 32,
  parameter int unsigned WORD_WIDTH      = 32,
  parameter int unsigned LINE_WORDS      = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
);
  localparam int unsigned LINE_WIDTH  = LINE_WORDS * WORD_WIDTH;
  localparam int unsigned COUNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

  logic                     reqValid;
  logic                     reqReady;
  logic [ADDRESS_WIDTH-1:0] reqAddress;
  logic                     reqWen;
  logic [LINE_WIDTH-1:0]    reqDataIn;
  logic [LINE_WORDS-1:0]    reqWordMask;
  logic                     respValid;
  logic                     respReady;
  logic [LINE_WIDTH-1:0]    respDataOut;
  logic                     respWrite;
  logic [COUNT_WIDTH-1:0]   inflight;

  modport master (
    output reqValid, reqAddress, reqWen, reqDataIn, reqWordMask, respReady,
    input  reqReady, respValid, respDataOut, respWrite, inflight
  );

  modport slave (
    input  reqValid, reqAddress, reqWen, reqDataIn, reqWordMask, respReady,
    output reqReady, respValid, respDataOut, respWrite, inflight
  );
endinterface

// File: rtl/pipelined_line_memory.sv
// Behavioural next-level memory: masked line writes, fixed-latency pipeline,
// in-order output FIFO and up to MAX_OUTSTANDING requests in flight.
module pipelined_line_memory #(
  parameter int unsigned ADDRESS_WIDTH   = 32,
  parameter int unsigned WORD_WIDTH      = 32,
  parameter int unsigned LINE_WORDS      = 4,
  parameter int unsigned ENTRIES         = 1024,
  parameter int unsigned DELAY           = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipelined_line_memory_if.slave bus
);
  localparam int unsigned LINE_WIDTH = LINE_WORDS * WORD_WIDTH;
  localparam int unsigned OFF        = $clog2(LINE_WIDTH / 8);
  localparam int unsigned IDX_W      = $clog2(ENTRIES);
  localparam int unsigned CNT_W      = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  // Zero at time 0 and deliberately outside the reset domain.
  logic [LINE_WIDTH-1:0] mem [ENTRIES] = '{default: '0};

  logic [IDX_W-1:0]      idx;
  logic [LINE_WIDTH-1:0] cur_line;
  logic [LINE_WIDTH-1:0] next_line;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [CNT_W-1:0]      inflight_q;
  logic                  unused_addr;

  logic [DELAY-1:0]      pipe_valid;
  logic [DELAY-1:0]      pipe_write;
  logic [LINE_WIDTH-1:0] pipe_data [DELAY];

  logic [LINE_WIDTH-1:0]      fifo_data [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] fifo_write;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           fifo_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign idx         = bus.reqAddress[OFF +: IDX_W];
  assign cur_line    = mem[idx];
  assign unused_addr = ^bus.reqAddress;

  // For reads next_line is the unmodified snapshot; for writes it is the merged line.
  always_comb begin
    next_line = cur_line;
    for (int unsigned w = 0; w < LINE_WORDS; w++) begin
      if (bus.reqWen && bus.reqWordMask[w]) begin
        next_line[w*WORD_WIDTH +: WORD_WIDTH] = bus.reqDataIn[w*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  assign bus.reqReady = rst_n && (inflight_q < CNT_W'(MAX_OUTSTANDING));
  assign accept       = bus.reqValid && bus.reqReady;
  assign push         = pipe_valid[DELAY-1];
  assign pop          = (fifo_count != '0) && bus.respReady;

  always_ff @(posedge clk) begin
    if (accept && bus.reqWen) begin
      mem[idx] <= next_line;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= accept;
      for (int unsigned i = 1; i < DELAY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    pipe_data[0]  <= next_line;
    pipe_write[0] <= bus.reqWen;
    for (int unsigned i = 1; i < DELAY; i++) begin
      pipe_data[i]  <= pipe_data[i-1];
      pipe_write[i] <= pipe_write[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr]  <= pipe_data[DELAY-1];
      fifo_write[wr_ptr] <= pipe_write[DELAY-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      inflight_q <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
      else if (!push && pop) fifo_count <= fifo_count - CNT_W'(1);
      if (accept && !pop)      inflight_q <= inflight_q + CNT_W'(1);
      else if (!accept && pop) inflight_q <= inflight_q - CNT_W'(1);
    end
  end

  // Head is gated so an empty FIFO (including during reset) presents zero.
  assign bus.respValid   = (fifo_count != '0);
  assign bus.respDataOut = bus.respValid ? fifo_data[rd_ptr] : '0;
  assign bus.respWrite   = bus.respValid ? fifo_write[rd_ptr] : 1'b0;
  assign bus.inflight    = inflight_q;

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (fifo_count == CNT_W'(MAX_OUTSTANDING))));
endmodule

// File: tb/tb_pipelined_line_memory.sv
// Bench for pipelined_line_memory: directed scenarios plus randomized traffic,
// checked against a line-array/expected-queue reference model.
module tb_pipelined_line_memory;
  localparam int unsigned AW     = 32;
  localparam int unsigned WW     = 32;
  localparam int unsigned LW     = 4;
  localparam int unsigned EN     = 1024;
  localparam int unsigned DL     = 4;
  localparam int unsigned MO     = 4;
  localparam int unsigned LINE_W = LW * WW;
  localparam int unsigned OFF    = 4;
  localparam int unsigned IW     = 10;
  localparam int unsigned CW     = $clog2(MO + 1);

  logic clk;
  logic rst_n;

  pipelined_line_memory_if #(.ADDRESS_WIDTH(AW), .WORD_WIDTH(WW), .LINE_WORDS(LW),
                             .MAX_OUTSTANDING(MO)) bus ();

  pipelined_line_memory #(.ADDRESS_WIDTH(AW), .WORD_WIDTH(WW), .LINE_WORDS(LW),
                          .ENTRIES(EN), .DELAY(DL), .MAX_OUTSTANDING(MO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [LINE_W-1:0] data;
    logic              wr;
    int unsigned       due;
  } exp_t;

  logic [LINE_W-1:0] ref_mem [EN];
  exp_t              q [$];
  int unsigned       cyc;
  int                checks;
  int                errors;
  logic              last_acc;
  logic              last_pop;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout cyc %0d", cyc);
    $fatal(1);
  end

  // One clock of traffic: observe at negedge, update the model at the edge.
  task automatic step();
    logic acc, pop, exp_valid, exp_ready;
    logic [AW-1:0] a;
    logic w;
    logic [LINE_W-1:0] d, line;
    logic [LW-1:0] m;
    int unsigned ix;
    @(negedge clk);
    acc = bus.reqValid && bus.reqReady;
    pop = bus.respValid && bus.respReady;
    a = bus.reqAddress; w = bus.reqWen; d = bus.reqDataIn; m = bus.reqWordMask;
    exp_valid = (rst_n === 1'b1) && (q.size() > 0) && (q[0].due <= cyc);
    exp_ready = (rst_n === 1'b1) && (q.size() < MO);
    checks++;
    if (bus.respValid !== exp_valid) begin
      errors++; $display("FAIL sb_respValid cyc %0d got %b exp %b", cyc, bus.respValid, exp_valid);
    end
    checks++;
    if (bus.inflight !== CW'(q.size())) begin
      errors++; $display("FAIL sb_inflight cyc %0d got %0d exp %0d", cyc, bus.inflight, q.size());
    end
    checks++;
    if (bus.reqReady !== exp_ready) begin
      errors++; $display("FAIL sb_reqReady cyc %0d got %b exp %b", cyc, bus.reqReady, exp_ready);
    end
    if (pop) begin
      checks++;
      if (q.size() == 0) begin
        errors++; $display("FAIL sb_spurious_resp cyc %0d got %h exp none", cyc, bus.respDataOut);
      end else if (bus.respDataOut !== q[0].data || bus.respWrite !== q[0].wr) begin
        errors++;
        $display("FAIL sb_resp cyc %0d got %h/%b exp %h/%b", cyc, bus.respDataOut, bus.respWrite,
                 q[0].data, q[0].wr);
      end
    end
    last_acc = acc;
    last_pop = pop;
    @(posedge clk);
    cyc++;
    if (pop && q.size() > 0) void'(q.pop_front());
    if (acc) begin
      ix = int'(a[OFF +: IW]);
      line = ref_mem[ix];
      if (w) begin
        for (int unsigned k = 0; k < LW; k++)
          if (m[k]) line[k*WW +: WW] = d[k*WW +: WW];
        ref_mem[ix] = line;
      end
      q.push_back('{data: line, wr: w, due: cyc + DL});
    end
    #1;
  endtask

  task automatic present(input logic [AW-1:0] a, input logic w, input logic [LINE_W-1:0] d,
                         input logic [LW-1:0] m);
    bus.reqValid = 1'b1; bus.reqAddress = a; bus.reqWen = w; bus.reqDataIn = d; bus.reqWordMask = m;
  endtask

  task automatic send(input logic [AW-1:0] a, input logic w, input logic [LINE_W-1:0] d,
                      input logic [LW-1:0] m);
    present(a, w, d, m);
    for (int i = 0; i < 50; i++) begin
      step();
      if (last_acc) break;
    end
    checks++;
    if (!last_acc) begin
      errors++; $display("FAIL send_timeout addr %h got no accept exp accept", a);
    end
    bus.reqValid = 1'b0;
  endtask

  task automatic wait_resp();
    for (int i = 0; i < 50; i++) begin
      if (bus.respValid) break;
      step();
    end
    checks++;
    if (bus.respValid !== 1'b1) begin
      errors++; $display("FAIL resp_timeout got %b exp 1", bus.respValid);
    end
  endtask

  task automatic drain();
    bus.reqValid = 1'b0;
    bus.respReady = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0) break;
      step();
    end
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL drain_timeout got %0d pending exp 0", q.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.reqReady !== 1'b0 || bus.respValid !== 1'b0 || bus.inflight !== '0 ||
        bus.respDataOut !== '0 || bus.respWrite !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got rdy %b vld %b infl %0d data %h wr %b exp all 0",
               bus.reqReady, bus.respValid, bus.inflight, bus.respDataOut, bus.respWrite);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.reqReady !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got %b exp 1", bus.reqReady);
    end
    present('0, 1'b0, '0, '0);
    step();
    checks++;
    if (last_acc !== 1'b1) begin
      errors++; $display("FAIL first_accept got %b exp 1", last_acc);
    end
    drain();
  endtask

  task automatic test_single_read();
    int unsigned t0;
    send(32'h50, 1'b1, {32'h33, 32'h22, 32'h11, 32'h00}, 4'hf);
    drain();
    send(32'h50, 1'b0, '0, '0);
    t0 = cyc;
    wait_resp();
    checks++;
    if (cyc - t0 != DL) begin
      errors++; $display("FAIL read_latency got %0d exp %0d", cyc - t0, DL);
    end
    checks++;
    if (bus.respDataOut !== 128'h00000033_00000022_00000011_00000000 || bus.respWrite !== 1'b0) begin
      errors++; $display("FAIL read_data got %h/%b exp 00000033000000220000001100000000/0",
                         bus.respDataOut, bus.respWrite);
    end
    drain();
    checks++;
    if (bus.inflight !== '0) begin
      errors++; $display("FAIL read_inflight_zero got %0d exp 0", bus.inflight);
    end
  endtask

  task automatic test_masked_write();
    logic [AW-1:0] addrs [5];
    logic [LINE_W-1:0] expd;
    addrs[0] = 32'h40; addrs[1] = 32'h44; addrs[2] = 32'h48; addrs[3] = 32'h4c;
    addrs[4] = 32'h8000_004c;
    expd = {32'h0, 32'hcccccccc, 32'h0, 32'haaaaaaaa};
    send(32'h40, 1'b1, {32'hdddddddd, 32'hcccccccc, 32'hbbbbbbbb, 32'haaaaaaaa}, 4'b0101);
    wait_resp();
    checks++;
    if (bus.respWrite !== 1'b1 || bus.respDataOut !== expd) begin
      errors++; $display("FAIL mask_ack got %h/%b exp %h/1", bus.respDataOut, bus.respWrite, expd);
    end
    drain();
    for (int i = 0; i < 5; i++) begin
      send(addrs[i], 1'b0, '0, '0);
      wait_resp();
      checks++;
      if (bus.respDataOut !== expd || bus.respWrite !== 1'b0) begin
        errors++; $display("FAIL mask_alias_read addr %h got %h exp %h", addrs[i], bus.respDataOut, expd);
      end
      drain();
    end
  endtask

  task automatic test_back_to_back();
    int n_acc;
    for (int i = 0; i < 6; i++)
      send(AW'((8 + i) * 16), 1'b1, {4{32'(32'h1000 + i)}}, 4'hf);
    drain();
    bus.respReady = 1'b0;
    n_acc = 0;
    present(AW'(8 * 16), 1'b0, '0, '0);
    for (int i = 0; i < 10; i++) begin
      step();
      if (last_acc) begin
        n_acc++;
        if (n_acc < 6) present(AW'((8 + n_acc) * 16), 1'b0, '0, '0);
        else bus.reqValid = 1'b0;
      end
    end
    checks++;
    if (n_acc != 4 || bus.inflight !== CW'(4) || bus.reqReady !== 1'b0) begin
      errors++; $display("FAIL b2b_full got acc %0d infl %0d rdy %b exp 4 4 0", n_acc, bus.inflight, bus.reqReady);
    end
    bus.respReady = 1'b1;
    step();
    checks++;
    if (last_pop !== 1'b1 || last_acc !== 1'b0 || bus.reqReady !== 1'b1) begin
      errors++; $display("FAIL b2b_first_pop got pop %b acc %b rdy %b exp 1 0 1", last_pop, last_acc, bus.reqReady);
    end
    for (int i = 0; i < 40 && (n_acc < 6 || q.size() > 0); i++) begin
      step();
      if (last_acc) begin
        n_acc++;
        if (n_acc < 6) present(AW'((8 + n_acc) * 16), 1'b0, '0, '0);
        else bus.reqValid = 1'b0;
      end
    end
    checks++;
    if (n_acc != 6) begin
      errors++; $display("FAIL b2b_all_accepted got %0d exp 6", n_acc);
    end
    drain();
  endtask

  task automatic test_full_pipe();
    bus.respReady = 1'b0;
    for (int i = 0; i < 3; i++) send(AW'((8 + i) * 16), 1'b0, '0, '0);
    wait_resp();
    present(AW'(11 * 16), 1'b0, '0, '0);
    bus.respReady = 1'b1;
    step();
    checks++;
    if (last_acc !== 1'b1 || last_pop !== 1'b1 || bus.inflight !== CW'(3)) begin
      errors++; $display("FAIL full_same_cycle got acc %b pop %b infl %0d exp 1 1 3", last_acc, last_pop, bus.inflight);
    end
    bus.respReady = 1'b0;
    present(AW'(12 * 16), 1'b0, '0, '0);
    step();
    checks++;
    if (last_acc !== 1'b1 || bus.inflight !== CW'(4) || bus.reqReady !== 1'b0) begin
      errors++; $display("FAIL full_reach4 got acc %b infl %0d rdy %b exp 1 4 0", last_acc, bus.inflight, bus.reqReady);
    end
    present(AW'(13 * 16), 1'b0, '0, '0);
    bus.respReady = 1'b1;
    checks++;
    if (bus.reqReady !== 1'b0 || bus.respValid !== 1'b1) begin
      errors++; $display("FAIL full_pop_cycle got rdy %b vld %b exp 0 1", bus.reqReady, bus.respValid);
    end
    step();
    checks++;
    if (last_pop !== 1'b1 || last_acc !== 1'b0 || bus.inflight !== CW'(3) || bus.reqReady !== 1'b1) begin
      errors++; $display("FAIL full_after_pop got pop %b acc %b infl %0d rdy %b exp 1 0 3 1",
                         last_pop, last_acc, bus.inflight, bus.reqReady);
    end
    drain();
  endtask

  task automatic test_raw_order();
    send(32'h70, 1'b1, 128'h1, 4'hf);
    drain();
    present(32'h70, 1'b0, '0, '0);
    step();
    checks++;
    if (last_acc !== 1'b1) begin
      errors++; $display("FAIL raw_read_accept got %b exp 1", last_acc);
    end
    present(32'h70, 1'b1, 128'h9, 4'hf);
    step();
    checks++;
    if (last_acc !== 1'b1) begin
      errors++; $display("FAIL raw_write_accept got %b exp 1", last_acc);
    end
    bus.reqValid = 1'b0;
    wait_resp();
    checks++;
    if (bus.respWrite !== 1'b0 || bus.respDataOut !== 128'h1) begin
      errors++; $display("FAIL raw_first_resp got %h/%b exp 1/0", bus.respDataOut, bus.respWrite);
    end
    step();
    wait_resp();
    checks++;
    if (bus.respWrite !== 1'b1 || bus.respDataOut !== 128'h9) begin
      errors++; $display("FAIL raw_second_resp got %h/%b exp 9/1", bus.respDataOut, bus.respWrite);
    end
    drain();
  endtask

  task automatic test_reset_inflight();
    logic [LINE_W-1:0] x;
    int stale;
    x = {32'hfeed0003, 32'hfeed0002, 32'hfeed0001, 32'hfeed0000};
    bus.respReady = 1'b0;
    send(32'h80, 1'b0, '0, '0);
    send(32'h140, 1'b1, x, 4'hf);
    send(32'h90, 1'b0, '0, '0);
    repeat (3) step();
    checks++;
    if (bus.respValid !== 1'b1 || bus.inflight !== CW'(3)) begin
      errors++; $display("FAIL rst_pre got vld %b infl %0d exp 1 3", bus.respValid, bus.inflight);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.respValid !== 1'b0 || bus.inflight !== '0 || bus.reqReady !== 1'b0 ||
        bus.respDataOut !== '0 || bus.respWrite !== 1'b0) begin
      errors++; $display("FAIL rst_async got vld %b infl %0d rdy %b data %h wr %b exp 0 0 0 0 0",
                         bus.respValid, bus.inflight, bus.reqReady, bus.respDataOut, bus.respWrite);
    end
    q.delete();
    repeat (2) step();
    rst_n = 1'b1;
    bus.respReady = 1'b1;
    stale = 0;
    repeat (10) begin
      step();
      if (bus.respValid) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++; $display("FAIL rst_stale got %0d cycles valid exp 0", stale);
    end
    send(32'h140, 1'b0, '0, '0);
    wait_resp();
    checks++;
    if (bus.respDataOut !== x) begin
      errors++; $display("FAIL rst_write_persist got %h exp %h", bus.respDataOut, x);
    end
    drain();
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    last_acc = 1'b0;
    bus.reqValid = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if (last_acc) bus.reqValid = 1'b0;
      if (!bus.reqValid && $urandom_range(0, 3) != 0) begin
        a = $urandom();
        a[OFF +: IW] = IW'($urandom_range(32, 39));
        present(a, 1'($urandom_range(0, 1)), {$urandom(), $urandom(), $urandom(), $urandom()},
                LW'($urandom_range(0, 15)));
      end
      bus.respReady = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.reqValid = 1'b0; bus.reqAddress = '0; bus.reqWen = 1'b0;
    bus.reqDataIn = '0; bus.reqWordMask = '0; bus.respReady = 1'b1;
    for (int i = 0; i < EN; i++) ref_mem[i] = '0;
    cyc = 0; checks = 0; errors = 0; last_acc = 1'b0; last_pop = 1'b0;
    test_reset();
    test_single_read();
    test_masked_write();
    test_back_to_back();
    test_full_pipe();
    test_raw_order();
    test_reset_inflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
